// File: rtl/host_interface_burst_pkg.sv
// Opcode encodings and control-bit positions shared by the burst host interface
// and its testbench.
package host_interface_pkg;

  localparam logic [3:0] IDLE      = 4'd0;
  localparam logic [3:0] SETEP     = 4'd1;
  localparam logic [3:0] SETREG    = 4'd2;
  localparam logic [3:0] SETRVAL   = 4'd3;
  localparam logic [3:0] RDDATA    = 4'd4;
  localparam logic [3:0] RESETRVAL = 4'd5;
  localparam logic [3:0] SETLEN    = 4'd6;

  localparam int CTL_RDWR = 1;

  typedef enum logic [2:0] {
    OP_IDLE,
    OP_SETEP,
    OP_SETREG,
    OP_SETRVAL,
    OP_RDDATA,
    OP_RESETRVAL,
    OP_SETLEN
  } op_e;

  // Every unassigned code collapses onto IDLE so the decoder never sees an illegal opcode.
  function automatic op_e decode_op(input logic [3:0] code);
    op_e op;
    case (code)
      SETEP:     op = OP_SETEP;
      SETREG:    op = OP_SETREG;
      SETRVAL:   op = OP_SETRVAL;
      RDDATA:    op = OP_RDDATA;
      RESETRVAL: op = OP_RESETRVAL;
      SETLEN:    op = OP_SETLEN;
      default:   op = OP_IDLE;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/host_interface_burst_if.sv
// Host-side GPIF pins plus the device-interface register bus of the burst host interface.
interface host_interface_burst_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 16
);

  logic [3:0]            state;
  logic [2:0]            ctl;
  logic [DATA_WIDTH-1:0] data_in;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  data_oe;
  logic                  rdy;

  logic [ADDR_WIDTH-1:0] di_ep_addr;
  logic [ADDR_WIDTH-1:0] di_reg_addr;
  logic [DATA_WIDTH-1:0] di_reg_data_in;
  logic [DATA_WIDTH-1:0] di_reg_data_out;
  logic                  di_write;
  logic                  di_read;
  logic                  di_reset;
  logic                  di_rd_ready;
  logic                  di_wr_ready;

  // The master side is the host controller together with the device fabric.
  modport master (
    output state, ctl, data_in, di_reg_data_out, di_rd_ready, di_wr_ready,
    input  data_out, data_oe, rdy, di_ep_addr, di_reg_addr, di_reg_data_in,
    input  di_write, di_read, di_reset
  );

  modport slave (
    input  state, ctl, data_in, di_reg_data_out, di_rd_ready, di_wr_ready,
    output data_out, data_oe, rdy, di_ep_addr, di_reg_addr, di_reg_data_in,
    output di_write, di_read, di_reset
  );

endinterface

// File: rtl/host_interface_burst_counter.sv
// Burst-length tracker: remaining beats plus an unlimited flag that is set by a zero length.
module hi_burst_counter #(
  parameter int LEN_WIDTH = 16
) (
  input  logic                 if_clock,
  input  logic                 reset,
  input  logic                 load,
  input  logic [LEN_WIDTH-1:0] load_value,
  input  logic                 dec,
  output logic                 done
);

  logic [LEN_WIDTH-1:0] remaining;
  logic                 unlimited;

  // Unlimited bursts never count down; a finished burst stays parked at zero.
  always_ff @(posedge if_clock or posedge reset) begin
    if (reset) begin
      remaining <= '0;
      unlimited <= 1'b1;
    end else if (load) begin
      remaining <= load_value;
      unlimited <= (load_value == '0);
    end else if (dec && !unlimited && (remaining != '0)) begin
      remaining <= remaining - LEN_WIDTH'(1);
    end
  end

  assign done = !unlimited && (remaining == '0);

endmodule

// File: rtl/host_interface_burst.sv
// Decodes registered GPIF opcodes and strobes into device register accesses with
// programmable burst length and auto-incrementing register address.
module host_interface_burst
  import host_interface_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 16,
  parameter int LEN_WIDTH  = 16,
  parameter int AUTO_INC   = 1
) (
  input logic                  if_clock,
  input logic                  reset,
  host_interface_burst_if.slave bus
);

  logic [3:0]            state_q;
  logic [3:0]            state_qq;
  logic [2:0]            ctl_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  entry_q;
  logic [ADDR_WIDTH-1:0] ep_addr_q;
  logic [ADDR_WIDTH-1:0] reg_addr_q;
  logic [DATA_WIDTH-1:0] wr_data_q;
  logic                  write_q;
  logic                  read_q;
  logic                  reset_q;

  op_e  op;
  logic change;
  logic strobe;
  logic done;
  logic beat;
  logic unused_ctl;

  logic write_next;
  logic read_next;
  logic reset_next;
  logic ep_load;
  logic reg_load;
  logic len_load;
  logic rdy_c;
  logic oe_c;

  assign op         = decode_op(state_q);
  assign change     = (state_q != state_qq);
  assign strobe     = ctl_q[CTL_RDWR];
  assign beat       = write_next || read_next;
  assign unused_ctl = ctl_q[0] ^ ctl_q[2];

  // The cycle in which a new opcode first appears only arms entry; it never acts on strobes.
  always_comb begin
    rdy_c      = 1'b0;
    oe_c       = 1'b0;
    write_next = 1'b0;
    read_next  = 1'b0;
    reset_next = 1'b0;
    ep_load    = 1'b0;
    reg_load   = 1'b0;
    len_load   = 1'b0;
    case (op)
      OP_SETEP: begin
        rdy_c   = 1'b1;
        ep_load = strobe && !change;
      end
      OP_SETREG: begin
        rdy_c    = 1'b1;
        reg_load = strobe && !change;
      end
      OP_SETLEN: begin
        rdy_c    = 1'b1;
        len_load = strobe && !change;
      end
      OP_SETRVAL: begin
        rdy_c      = bus.di_wr_ready && !done;
        write_next = strobe && !change && bus.di_wr_ready && !done;
      end
      OP_RDDATA: begin
        rdy_c     = bus.di_rd_ready && !done;
        oe_c      = !change;
        read_next = strobe && !change && bus.di_rd_ready && !done;
      end
      OP_RESETRVAL: begin
        rdy_c      = 1'b1;
        reset_next = entry_q && !change;
      end
      default: begin
        rdy_c = 1'b0;
      end
    endcase
  end

  // Address advances the cycle after a pulse so the device sees a stable address with it.
  always_ff @(posedge if_clock or posedge reset) begin
    if (reset) begin
      state_q    <= '0;
      state_qq   <= '0;
      ctl_q      <= '0;
      data_q     <= '0;
      entry_q    <= 1'b0;
      ep_addr_q  <= '0;
      reg_addr_q <= '0;
      wr_data_q  <= '0;
      write_q    <= 1'b0;
      read_q     <= 1'b0;
      reset_q    <= 1'b0;
    end else begin
      state_q  <= bus.state;
      state_qq <= state_q;
      ctl_q    <= bus.ctl;
      data_q   <= bus.data_in;
      entry_q  <= change;
      write_q  <= write_next;
      read_q   <= read_next;
      reset_q  <= reset_next;
      if (write_next) begin
        wr_data_q <= data_q;
      end
      if (ep_load) begin
        ep_addr_q <= data_q[ADDR_WIDTH-1:0];
      end
      if (reg_load) begin
        reg_addr_q <= data_q[ADDR_WIDTH-1:0];
      end else if ((AUTO_INC != 0) && (write_q || read_q)) begin
        reg_addr_q <= reg_addr_q + ADDR_WIDTH'(1);
      end
    end
  end

  hi_burst_counter #(
    .LEN_WIDTH (LEN_WIDTH)
  ) u_counter (
    .if_clock   (if_clock),
    .reset      (reset),
    .load       (len_load),
    .load_value (data_q[LEN_WIDTH-1:0]),
    .dec        (beat),
    .done       (done)
  );

  assign bus.data_out       = bus.di_reg_data_out;
  assign bus.data_oe        = oe_c;
  assign bus.rdy            = rdy_c;
  assign bus.di_ep_addr     = ep_addr_q;
  assign bus.di_reg_addr    = reg_addr_q;
  assign bus.di_reg_data_in = wr_data_q;
  assign bus.di_write       = write_q;
  assign bus.di_read        = read_q;
  assign bus.di_reset       = reset_q;

endmodule

// File: tb/tb_host_interface_burst.sv
// Scoreboard bench for host_interface_burst: an opcode-level reference model predicts
// every device pulse, and a monitor matches the pulses as the DUT emits them.
module tb_host_interface_burst;
  import host_interface_pkg::*;

  localparam int DW       = 16;
  localparam int AW       = 16;
  localparam int LW       = 16;
  localparam int AUTO_INC = 1;

  typedef struct packed {
    logic [1:0]    kind;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } exp_t;

  logic if_clock = 1'b0;
  logic reset    = 1'b1;

  host_interface_burst_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  host_interface_burst #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .LEN_WIDTH  (LW),
    .AUTO_INC   (AUTO_INC)
  ) dut (
    .if_clock (if_clock),
    .reset    (reset),
    .bus      (bus)
  );

  always #5 if_clock = ~if_clock;

  int checks = 0;
  int errors = 0;

  exp_t          sbq[$];
  exp_t          mon_e;
  logic [AW-1:0] m_ep;
  logic [AW-1:0] m_reg;
  logic [LW-1:0] m_rem;
  bit            m_unl;
  logic [3:0]    m_prev;
  bit            m_entry;
  bit            pend_valid;
  bit            pend_rdy;
  bit            pend_oe;
  bit            next_wr;
  bit            next_rd;
  int            push_now;
  int            push_prev;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic modelReset();
    m_ep       = '0;
    m_reg      = '0;
    m_rem      = '0;
    m_unl      = 1'b1;
    m_prev     = IDLE;
    m_entry    = 1'b0;
    pend_valid = 1'b0;
    next_wr    = 1'b0;
    next_rd    = 1'b0;
    push_now   = 0;
    push_prev  = 0;
  endtask

  // Reference model: one call per host cycle, working from opcode rules on whole beats.
  task automatic modelStep(input logic [3:0] op, input bit strobe, input logic [DW-1:0] data,
                           input bit wr, input bit rd);
    bit change;
    bit done;
    int code;
    change    = (op != m_prev);
    code      = (op <= 4'd6) ? int'(op) : 0;
    done      = !m_unl && (m_rem == 0);
    push_prev = push_now;
    push_now  = 0;
    case (code)
      1, 2, 5, 6: pend_rdy = 1'b1;
      3:          pend_rdy = wr && !done;
      4:          pend_rdy = rd && !done;
      default:    pend_rdy = 1'b0;
    endcase
    pend_oe    = (code == 4) && !change;
    pend_valid = 1'b1;
    if (!change) begin
      case (code)
        1: if (strobe) m_ep = data[AW-1:0];
        2: if (strobe) m_reg = data[AW-1:0];
        6: if (strobe) begin
             m_rem = data[LW-1:0];
             m_unl = (data[LW-1:0] == 0);
           end
        3, 4: if (strobe && ((code == 3) ? wr : rd) && !done) begin
             sbq.push_back(exp_t'{(code == 3) ? 2'd0 : 2'd1, m_reg, (code == 3) ? data : '0});
             m_reg = m_reg + AW'(AUTO_INC);
             if (!m_unl) m_rem = m_rem - 1;
             push_now = 1;
           end
        5: if (m_entry) begin
             sbq.push_back(exp_t'{2'd2, '0, '0});
             push_now = 1;
           end
        default: ;
      endcase
    end
    m_entry = change;
    m_prev  = op;
  endtask

  // Readiness for a strobe is presented in the cycle its registered copy is decoded.
  task automatic applyStimulus(input logic [3:0] op, input bit strobe, input logic [DW-1:0] data,
                               input bit wr, input bit rd);
    @(negedge if_clock);
    bus.di_wr_ready     = next_wr;
    bus.di_rd_ready     = next_rd;
    bus.state           = op;
    bus.ctl             = {1'($urandom), strobe, 1'($urandom)};
    bus.data_in         = data;
    bus.di_reg_data_out = DW'($urandom);
    next_wr             = wr;
    next_rd             = rd;
    #1;
    if (pend_valid) begin
      checkOutput("rdy", 32'(bus.rdy), 32'(pend_rdy));
      checkOutput("data_oe", 32'(bus.data_oe), 32'(pend_oe));
    end
    modelStep(op, strobe, data, wr, rd);
  endtask

  task automatic enter(input logic [3:0] op);
    applyStimulus(op, 1'b0, DW'($urandom), 1'($urandom), 1'($urandom));
  endtask

  task automatic flushCheck(input string tag);
    logic [3:0] op;
    op = m_prev;
    repeat (3) applyStimulus(op, 1'b0, DW'($urandom), 1'b1, 1'b1);
    checkOutput({tag, "_ep_addr"}, 32'(bus.di_ep_addr), 32'(m_ep));
    checkOutput({tag, "_reg_addr"}, 32'(bus.di_reg_addr), 32'(m_reg));
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_rdy"}, 32'(bus.rdy), 32'd0);
    checkOutput({tag, "_data_oe"}, 32'(bus.data_oe), 32'd0);
    checkOutput({tag, "_pulses"}, 32'({bus.di_write, bus.di_read, bus.di_reset}), 32'd0);
    checkOutput({tag, "_ep_addr"}, 32'(bus.di_ep_addr), 32'd0);
    checkOutput({tag, "_reg_addr"}, 32'(bus.di_reg_addr), 32'd0);
    checkOutput({tag, "_wr_data"}, 32'(bus.di_reg_data_in), 32'd0);
  endtask

  task automatic releaseReset();
    @(negedge if_clock);
    bus.state       = IDLE;
    bus.ctl         = '0;
    bus.di_wr_ready = 1'b0;
    bus.di_rd_ready = 1'b0;
    reset           = 1'b0;
    #1;
    checkOutput("rdy_at_release", 32'(bus.rdy), 32'd0);
    @(posedge if_clock);
    #1;
    checkOutput("rdy_idle_after_release", 32'(bus.rdy), 32'd0);
  endtask

  // Mid-cycle reset: the two most recent model beats were never registered as pulses.
  task automatic assertReset();
    #1;
    reset = 1'b1;
    #1;
    checkOutput("reset_inflight", 32'(sbq.size()), 32'(push_now + push_prev));
    sbq.delete();
    checkResetOutputs("async_reset");
    modelReset();
    repeat (2) @(negedge if_clock);
    releaseReset();
  endtask

  initial begin : monitor
    forever begin
      @(posedge if_clock);
      #1;
      if (!reset && (bus.di_write || bus.di_read || bus.di_reset)) begin
        if (sbq.size() == 0) begin
          checkOutput("unexpected_pulse", 32'({bus.di_write, bus.di_read, bus.di_reset}), 32'd0);
        end else begin
          mon_e = sbq.pop_front();
          checkOutput("pulse_kind", 32'({bus.di_write, bus.di_read, bus.di_reset}),
                      (mon_e.kind == 2'd0) ? 32'd4 : (mon_e.kind == 2'd1) ? 32'd2 : 32'd1);
          if (mon_e.kind == 2'd0) begin
            checkOutput("write_addr", 32'(bus.di_reg_addr), 32'(mon_e.addr));
            checkOutput("write_data", 32'(bus.di_reg_data_in), 32'(mon_e.data));
          end else if (mon_e.kind == 2'd1) begin
            checkOutput("read_addr", 32'(bus.di_reg_addr), 32'(mon_e.addr));
            checkOutput("read_data_out", 32'(bus.data_out), 32'(bus.di_reg_data_out));
          end
        end
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    logic [3:0] op;
    int         r;
    int         len;
    bit         rd_pat [4];
    bus.state           = IDLE;
    bus.ctl             = '0;
    bus.data_in         = '0;
    bus.di_reg_data_out = '0;
    bus.di_wr_ready     = 1'b0;
    bus.di_rd_ready     = 1'b0;
    modelReset();
    #12;
    checkResetOutputs("por");
    releaseReset();

    // Endpoint and register address loads.
    enter(SETEP);
    applyStimulus(SETEP, 1'b1, 16'h0012, 1'b0, 1'b0);
    enter(SETREG);
    applyStimulus(SETREG, 1'b1, 16'h0040, 1'b0, 1'b0);
    flushCheck("addr_load");

    // Three-beat write burst with five strobes offered back to back.
    enter(SETLEN);
    applyStimulus(SETLEN, 1'b1, 16'd3, 1'b1, 1'b1);
    enter(SETREG);
    applyStimulus(SETREG, 1'b1, 16'h0040, 1'b1, 1'b1);
    enter(SETRVAL);
    for (int i = 0; i < 5; i++) applyStimulus(SETRVAL, 1'b1, DW'(16'hA0 + i), 1'b1, 1'b0);
    flushCheck("write_burst");

    // Unlimited read burst with device readiness toggling.
    rd_pat = '{1'b1, 1'b0, 1'b1, 1'b1};
    enter(SETLEN);
    applyStimulus(SETLEN, 1'b1, 16'd0, 1'b1, 1'b1);
    enter(RDDATA);
    for (int i = 0; i < 4; i++) applyStimulus(RDDATA, 1'b1, DW'($urandom), 1'b0, rd_pat[i]);
    flushCheck("read_burst");

    // Register address wraps from the top of the space.
    enter(SETREG);
    applyStimulus(SETREG, 1'b1, 16'hFFFF, 1'b1, 1'b1);
    enter(SETLEN);
    applyStimulus(SETLEN, 1'b1, 16'd2, 1'b1, 1'b1);
    enter(SETRVAL);
    for (int i = 0; i < 3; i++) applyStimulus(SETRVAL, 1'b1, DW'($urandom), 1'b1, 1'b0);
    flushCheck("addr_wrap");

    // Held RESETRVAL, then an opcode change on top of a strobe mid-burst.
    enter(RESETRVAL);
    for (int i = 0; i < 10; i++) applyStimulus(RESETRVAL, 1'($urandom), DW'($urandom), 1'b1, 1'b1);
    enter(SETLEN);
    applyStimulus(SETLEN, 1'b1, 16'd0, 1'b1, 1'b1);
    enter(SETRVAL);
    for (int i = 0; i < 3; i++) applyStimulus(SETRVAL, 1'b1, DW'($urandom), 1'b1, 1'b1);
    applyStimulus(RDDATA, 1'b1, DW'($urandom), 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) applyStimulus(RDDATA, 1'b1, DW'($urandom), 1'b1, 1'b1);
    flushCheck("op_change");

    // Reset in the middle of a write burst.
    enter(SETLEN);
    applyStimulus(SETLEN, 1'b1, 16'd5, 1'b1, 1'b1);
    enter(SETRVAL);
    applyStimulus(SETRVAL, 1'b1, DW'($urandom), 1'b1, 1'b1);
    applyStimulus(SETRVAL, 1'b1, DW'($urandom), 1'b1, 1'b1);
    assertReset();
    flushCheck("post_reset");

    // Randomised opcode segments, including unassigned codes.
    for (int s = 0; s < 60; s++) begin
      r   = int'($urandom_range(0, 8));
      op  = (r <= 6) ? 4'(r) : 4'($urandom_range(7, 15));
      len = int'($urandom_range(1, 8));
      for (int k = 0; k < len; k++) begin
        applyStimulus(op, ($urandom_range(0, 3) != 0),
                      (op == SETLEN) ? DW'($urandom_range(0, 4)) :
                      (op == SETREG) ? DW'(16'hFFF0 + $urandom_range(0, 31)) : DW'($urandom),
                      ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0));
      end
    end
    flushCheck("random");

    checkOutput("scoreboard_drain", 32'(sbq.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
